// File: rtl/alu_32.sv
// alu_32: registered 32-bit integer ALU (add/sub, bitwise, shifts, set-less-than).
// All four outputs are captured on the rising clock edge, giving one cycle of latency.
module alu_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       sel,
    output logic             carryOut,
    output logic             overflow,
    output logic             zero,
    output logic [WIDTH-1:0] result
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_SLL  = 4'h8;
    localparam logic [3:0] OP_SRL  = 4'hA;
    localparam logic [3:0] OP_SRA  = 4'hB;
    localparam logic [3:0] OP_SLT  = 4'hC;
    localparam logic [3:0] OP_SLTU = 4'hE;

    // Reduction NOR kept as a helper so the zero flag is derived the same way everywhere.
    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b0}});
    endfunction

    logic [WIDTH-1:0] b_op_s;
    logic             cin_s;
    logic [WIDTH:0]   sum_s;
    logic [SHW-1:0]   shamt_s;
    logic [WIDTH-1:0] sra_s;
    logic             is_sub_s;

    logic [WIDTH-1:0] result_d, result_q;
    logic             carry_d, carry_q;
    logic             ovf_d, ovf_q;
    logic             zero_d, zero_q;

    // Shared adder: subtraction reuses it as A + ~B + 1 so carry means "no borrow".
    always_comb begin
        is_sub_s = (sel == OP_SUB);
        if (is_sub_s) begin
            b_op_s = ~B;
            cin_s  = 1'b1;
        end else begin
            b_op_s = B;
            cin_s  = 1'b0;
        end
        sum_s   = {1'b0, A} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, cin_s};
        shamt_s = B[SHW-1:0];
        sra_s   = $unsigned($signed(A) >>> shamt_s);
    end

    // Next-state selection for result and flags; unused codes yield zero with flags clear.
    always_comb begin
        result_d = {WIDTH{1'b0}};
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        case (sel)
            OP_ADD: begin
                result_d = sum_s[WIDTH-1:0];
                carry_d  = sum_s[WIDTH];
                ovf_d    = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                result_d = sum_s[WIDTH-1:0];
                carry_d  = sum_s[WIDTH];
                ovf_d    = (A[WIDTH-1] != B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  result_d = A & B;
            OP_OR:   result_d = A | B;
            OP_XOR:  result_d = A ^ B;
            OP_SLL:  result_d = A << shamt_s;
            OP_SRL:  result_d = A >> shamt_s;
            OP_SRA:  result_d = sra_s;
            // True signed compare, not derived from the subtract sign, so overflow cannot corrupt it.
            OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, (A < B)};
            default: begin
                result_d = {WIDTH{1'b0}};
                carry_d  = 1'b0;
                ovf_d    = 1'b0;
            end
        endcase
        zero_d = is_zero(result_d);
    end

    // Output registers; reset state keeps zero consistent with a cleared result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= {WIDTH{1'b0}};
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign result   = result_q;
    assign carryOut = carry_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_alu_32.sv
// Table-driven bench for alu_32 with hand-computed expected values.
module tb_alu_32;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  sel;
    logic        carryOut;
    logic        overflow;
    logic        zero;
    logic [31:0] result;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_32 #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .sel      (sel),
        .carryOut (carryOut),
        .overflow (overflow),
        .zero     (zero),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] r, input logic c, input logic v, input logic z);
        vec_t t;
        t.sel = s; t.a = a; t.b = b; t.res = r; t.c = c; t.v = v; t.z = z;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] er, input logic ec,
                         input logic ev, input logic ez);
        n_cmp++;
        if ({result, carryOut, overflow, zero} !== {er, ec, ev, ez}) begin
            n_fail++;
            $display("FAIL %s: got res=%h c=%b v=%b z=%b, want res=%h c=%b v=%b z=%b",
                     name, result, carryOut, overflow, zero, er, ec, ev, ez);
        end
    endtask

    initial begin
        // sel, A, B, result, carry, overflow, zero
        vecs.push_back(mk(4'h0, 32'h2, 32'h3, 32'h5, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'h1, 32'h2, 32'h3, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'h2, 32'h2, 32'h3, 32'h2, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'h4, 32'h2, 32'h3, 32'h3, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'h6, 32'h2, 32'h3, 32'h1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'h8, 32'h2, 32'h3, 32'h10, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'hA, 32'h2, 32'h3, 32'h0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(4'hC, 32'h2, 32'h3, 32'h1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'hE, 32'h2, 32'h3, 32'h1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'h0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(4'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(4'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(4'h1, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(4'h1, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(4'h1, 32'h3, 32'h2, 32'h1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(4'h1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(4'hC, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'hE, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(4'hC, 32'h80000000, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'hE, 32'h80000000, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(4'h8, 32'h1, 32'h3F, 32'h80000000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'hB, 32'h80000000, 32'h4, 32'hF8000000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'hA, 32'h80000000, 32'h4, 32'h08000000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'h8, 32'h12345678, 32'h0, 32'h12345678, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'hA, 32'h87654321, 32'hFFFFFFE0, 32'h87654321, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'hB, 32'h80000001, 32'h20, 32'h80000001, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'hB, 32'h40000000, 32'h1E, 32'h1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'h5, 32'h2, 32'h3, 32'h0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(4'h3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(4'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(4'h9, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(4'hD, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(4'hF, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1));

        // Asynchronous reset with arbitrary inputs, checked before any clock edge.
        reset = 1'b0;
        A = 32'hDEADBEEF; B = 32'h12345678; sel = 4'h0;
        #2;
        reset = 1'b1;
        #1;
        check("reset_async", 32'h0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("reset_hold", 32'h0, 1'b0, 1'b0, 1'b1);

        @(negedge clk);
        reset = 1'b0;

        // Table: one op applied per cycle, checked just after the capturing edge.
        foreach (vecs[i]) begin
            A = vecs[i].a; B = vecs[i].b; sel = vecs[i].sel;
            @(posedge clk); #1;
            check($sformatf("vec%0d_sel%h", i, vecs[i].sel), vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].z);
            @(negedge clk);
        end

        // Reset between two back-to-back ops.
        A = 32'h7; B = 32'h8; sel = 4'h0;
        @(posedge clk); #1;
        check("pre_reset_op", 32'hF, 1'b0, 1'b0, 1'b0);
        A = 32'hFFFFFFFF; B = 32'h1; sel = 4'h0;
        #2;
        reset = 1'b1;
        #1;
        check("midop_reset_async", 32'h0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("midop_reset_hold", 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        A = 32'h80000000; B = 32'h80000000; sel = 4'h0;
        @(posedge clk); #1;
        check("post_reset_op", 32'h0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        A = 32'h1; B = 32'h1; sel = 4'h0;
        @(posedge clk); #1;
        check("post_reset_next", 32'h2, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_32.md
Name: alu_32

Overview:
- 32-bit integer ALU for the single-cycle processor datapath. Performs add, subtract, bitwise, shift and set-less-than operations selected by a 4-bit code.
- Produces a result plus carry, overflow and zero flags.
- Operands and select are sampled on the rising clock edge. Outputs are registered, so they are valid one cycle later.

Parameters:
- WIDTH, 32, operand and result width. Shift amount uses the low log2(WIDTH) bits of B.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- A  input  32  operand A
- B  input  32  operand B; shift amount source for shifts
- sel  input  4  operation select
- carryOut  output  1  carry flag (registered)
- overflow  output  1  signed overflow flag (registered)
- zero  output  1  high when result is all zeros (registered)
- result  output  32  operation result (registered)

Behaviour:
- Reset (asynchronous, active-high): result=0, carryOut=0, overflow=0, zero=1. This keeps the zero==(result==0) invariant. Outputs hold these values while reset is high.
- Every rising clk with reset low: compute from A, B, sel and register all four outputs. Latency is 1 cycle. No enable and no handshake; a new operation is accepted every cycle.
- sel encoding:
  - 0x0 ADD: A+B
  - 0x1 SUB: A-B, computed as A+~B+1
  - 0x2 AND: A&B
  - 0x4 OR: A|B
  - 0x6 XOR: A^B
  - 0x8 SLL: A << B[4:0]
  - 0xA SRL: A >> B[4:0], logical, zero fill
  - 0xB SRA: A >>> B[4:0], sign fill
  - 0xC SLT: result = {31'b0, signed(A)<signed(B)}
  - 0xE SLTU: result = {31'b0, unsigned(A)<unsigned(B)}
  - All other codes (0x3,0x5,0x7,0x9,0xD,0xF): result=0, carryOut=0, overflow=0, zero=1.
- carryOut:
  - ADD: carry out of bit 31.
  - SUB: carry out of A+~B+1, so 1 = no borrow (A>=B unsigned) and 0 = borrow.
  - All other ops: 0.
- overflow:
  - ADD: A[31]==B[31] and result[31]!=A[31].
  - SUB: A[31]!=B[31] and result[31]!=A[31].
  - All other ops: 0.
- SLT uses the true signed comparison, correct even when A-B overflows. SLTU uses the unsigned comparison.
- zero = (result==0) for every op, including SLT/SLTU and undefined codes.
- Shifts use only B[4:0]; B[31:5] is ignored. A shift of 0 returns A unchanged.
- Wrap-around: ADD/SUB results are modulo 2^32.
- Reset asserted mid-operation: outputs clear immediately, without waiting for clk. The first edge after deassertion registers the then-present inputs.
- X/undriven inputs need no defined handling; the bench drives all inputs before releasing reset.

Test Plan:
- Reset: assert reset with arbitrary A/B/sel -> immediately result=0, carryOut=0, overflow=0, zero=1. Release, apply A=2, B=3, sel=0x0 -> next edge result=5, zero=0, carryOut=0, overflow=0.
- A=2, B=3 swept one op per cycle, each checked one edge after apply:
  - SUB -> 0xFFFFFFFF, carryOut=0
  - AND -> 0x2
  - OR -> 0x3
  - XOR -> 0x1
  - SLL -> 0x10
  - SRL -> 0x0 with zero=1
  - SLT -> 1
  - SLTU -> 1
- Arithmetic flags:
  - ADD 0x7FFFFFFF+0x1 -> 0x80000000, overflow=1, carryOut=0.
  - ADD 0xFFFFFFFF+0x1 -> 0x0, carryOut=1, zero=1, overflow=0.
  - SUB 0x80000000-0x1 -> 0x7FFFFFFF, overflow=1, carryOut=1.
  - SUB 5-5 -> 0, zero=1, carryOut=1.
- Signed vs unsigned compare:
  - A=0xFFFFFFFF, B=1: SLT -> 1, SLTU -> 0.
  - A=0x80000000, B=0x7FFFFFFF: SLT -> 1 (overflow case), SLTU -> 0.
- Shift edge cases:
  - SLL A=1, B=0x3F -> 0x80000000 (only B[4:0]=31 used).
  - SRA A=0x80000000, B=4 -> 0xF8000000.
  - SRL with same operands -> 0x08000000.
  - Shift by 0 returns A.
- Undefined sel 0x5 with A=2, B=3 -> result=0, zero=1, flags 0. Assert reset between two back-to-back ops -> outputs clear asynchronously, and the next op after release has 1-cycle latency.
